decoder_proj_core: RTL and testbench

- Registered multi-mode 4-bit decoder for the decoder project user area; wrapped by the project's formal/cover harness.
- Each enabled cycle it samples a 7-bit packed input: 4-bit data, 2-bit mode, enable.
- Outputs one of four decodings on a 16-bit bus with one cycle of latency: one-hot, hex 7-segment, thermometer, or BCD one-hot.
- Also reports a valid strobe, a BCD range-error flag and a running count of accepted decodes.

---
 rtl/decoder_proj_core.sv | 99 +++++++++
 tb/tb_decoder_proj_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/decoder_proj_core.sv
// rtl/decoder_proj_core.sv - registered multi-mode 4-bit decoder (one-hot, 7-seg, thermometer, BCD)
module decoder_proj_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       io_in,
    output logic [15:0]      io_out,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_SEG7   = 2'b01;
    localparam logic [1:0] MODE_THERM  = 2'b10;
    localparam logic [1:0] MODE_BCD    = 2'b11;

    logic [3:0]  data;
    logic [1:0]  mode;
    logic        enable;
    logic [6:0]  seg;
    logic [15:0] onehot;
    logic [15:0] therm;
    logic [15:0] next_out;
    logic        next_err;

    assign data   = io_in[3:0];
    assign mode   = io_in[5:4];
    assign enable = io_in[6];

    // Segment order is bit0=a .. bit6=g, active-high.
    always_comb begin
        seg = 7'h00;
        case (data)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    always_comb begin
        onehot = 16'h0000;
        therm  = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            onehot[k] = (data == 4'(k));
            therm[k]  = (4'(k) < data);
        end
    end

    always_comb begin
        next_out = 16'h0000;
        next_err = 1'b0;
        case (mode)
            MODE_ONEHOT: next_out = onehot;
            MODE_SEG7:   next_out = {9'h000, seg};
            MODE_THERM:  next_out = therm;
            MODE_BCD: begin
                if (data <= 4'd9) begin
                    next_out = onehot;
                end else begin
                    next_err = 1'b1;
                end
            end
            default: next_out = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_out <= 16'h0000;
            valid  <= 1'b0;
            err    <= 1'b0;
            count  <= '0;
        end else if (enable) begin
            io_out <= next_out;
            valid  <= 1'b1;
            err    <= next_err;
            count  <= count + CNT_W'(1);
        end else begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_proj_core.sv
// tb/tb_decoder_proj_core.sv - randomized and directed self-checking bench for decoder_proj_core
module tb_decoder_proj_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  io_in = 7'h00;
    logic [15:0] io_out;
    logic        valid;
    logic        err;
    logic [7:0]  count;

    int checks = 0;
    int errors = 0;

    decoder_proj_core #(.CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .valid  (valid),
        .err    (err),
        .count  (count)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [15:0] ref_decode(input int d, input int m);
        int v;
        case (m)
            0: v = 1 << d;
            1: v = int'(seg_tab[d]);
            2: v = (1 << d) - 1;
            default: v = (d <= 9) ? (1 << d) : 0;
        endcase
        return 16'(v);
    endfunction

    logic [15:0] m_out;
    logic        m_valid, m_err, m_known = 1'b0;
    int          m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_out   <= 16'h0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
            m_known <= 1'b1;
        end else if (io_in[6]) begin
            m_out   <= ref_decode(int'(io_in[3:0]), int'(io_in[5:4]));
            m_valid <= 1'b1;
            m_err   <= (io_in[5:4] == 2'b11) && (io_in[3:0] > 4'd9);
            m_cnt   <= (m_cnt + 1) % 256;
        end else begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("model.io_out", int'(io_out), int'(m_out));
            chk("model.valid",  int'(valid),  int'(m_valid));
            chk("model.err",    int'(err),    int'(m_err));
            chk("model.count",  int'(count),  m_cnt);
        end
    end

    task automatic cyc(input logic r, input logic [6:0] v);
        rst   = r;
        io_in = v;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [6:0] acc(input logic [1:0] m, input logic [3:0] d);
        return {1'b1, m, d};
    endfunction

    int saved;

    initial begin
        @(negedge clk);
        cyc(1'b1, 7'h7F);
        chk("rst1.io_out", int'(io_out), 0);
        chk("rst1.valid", int'(valid), 0);
        cyc(1'b1, 7'h7F);
        chk("rst2.io_out", int'(io_out), 0);
        chk("rst2.err", int'(err), 0);
        chk("rst2.count", int'(count), 0);

        cyc(1'b0, 7'b1011010);
        chk("seg_a.io_out", int'(io_out), 'h0077);
        chk("seg_a.valid", int'(valid), 1);
        chk("seg_a.err", int'(err), 0);
        chk("seg_a.count", int'(count), 1);
        for (int d = 0; d < 16; d++) begin
            cyc(1'b0, acc(2'b01, 4'(d)));
            chk("seg_seq.count", int'(count), 2 + d);
        end
        chk("seg_f.io_out", int'(io_out), 'h0071);

        cyc(1'b0, acc(2'b00, 4'd5));
        chk("onehot5", int'(io_out), 'h0020);
        cyc(1'b0, acc(2'b10, 4'd0));
        chk("therm0", int'(io_out), 'h0000);
        cyc(1'b0, acc(2'b10, 4'd4));
        chk("therm4", int'(io_out), 'h000F);
        cyc(1'b0, acc(2'b10, 4'd15));
        chk("therm15", int'(io_out), 'h7FFF);

        cyc(1'b0, acc(2'b11, 4'd9));
        chk("bcd9.io_out", int'(io_out), 'h0200);
        chk("bcd9.err", int'(err), 0);
        saved = int'(count);
        cyc(1'b0, acc(2'b11, 4'd12));
        chk("bcd12.io_out", int'(io_out), 0);
        chk("bcd12.err", int'(err), 1);
        chk("bcd12.valid", int'(valid), 1);
        chk("bcd12.count", int'(count), (saved + 1) % 256);
        cyc(1'b0, acc(2'b11, 4'd3));
        chk("bcd3.io_out", int'(io_out), 'h0008);
        chk("bcd3.err", int'(err), 0);

        cyc(1'b0, acc(2'b00, 4'd7));
        chk("hold_acc", int'(io_out), 'h0080);
        saved = int'(count);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, {1'b0, 6'($urandom)});
            chk("hold.io_out", int'(io_out), 'h0080);
            chk("hold.valid", int'(valid), 0);
            chk("hold.count", int'(count), saved);
        end

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), 7'($urandom));
        end

        cyc(1'b1, 7'h00);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, {1'b1, 6'($urandom)});
            if (i == 254) chk("wrap.count255", int'(count), 255);
        end
        chk("wrap.count0", int'(count), 0);

        cyc(1'b0, acc(2'b00, 4'd1));
        cyc(1'b0, acc(2'b01, 4'd2));
        cyc(1'b1, acc(2'b11, 4'd12));
        chk("midrst.io_out", int'(io_out), 0);
        chk("midrst.valid", int'(valid), 0);
        chk("midrst.err", int'(err), 0);
        chk("midrst.count", int'(count), 0);
        cyc(1'b0, acc(2'b10, 4'd8));
        chk("post_rst.count", int'(count), 1);
        chk("post_rst.io_out", int'(io_out), 'h00FF);

        cyc(1'b0, 7'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
